// File: rtl/lsu_subword.sv
// Load/store unit for a 64-bit word-addressed data memory: sized, extended loads
// and sub-word stores performed as read-modify-write of the containing doubleword.
module lsu_subword #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   merge_q;   // store data at accept, merged doubleword after RMW_RD
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;

    logic              accept, misaligned, illegal, req_bad;
    logic [5:0]        shamt;
    logic [XLEN-1:0]   lane, load_ext, size_mask, lane_mask, merged;

    assign accept  = req_valid & req_ready;
    assign illegal = req_store ? req_funct3[2] : (req_funct3 == 3'b111);
    assign req_bad = illegal | misaligned;

    // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Little-endian lane at byte offset addr[2:0].
    assign shamt = {addr_q[2:0], 3'b000};
    assign lane  = mem_rdata >> shamt;

    always_comb begin
        load_ext = lane;
        case (funct3_q)
            3'b000:  load_ext = {{56{lane[7]}},  lane[7:0]};
            3'b001:  load_ext = {{48{lane[15]}}, lane[15:0]};
            3'b010:  load_ext = {{32{lane[31]}}, lane[31:0]};
            3'b100:  load_ext = {56'd0, lane[7:0]};
            3'b101:  load_ext = {48'd0, lane[15:0]};
            3'b110:  load_ext = {32'd0, lane[31:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        size_mask = '1;
        case (funct3_q[1:0])
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
    end

    assign lane_mask = size_mask << shamt;
    assign merged    = (mem_rdata & ~lane_mask) | ((merge_q << shamt) & lane_mask);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_bad)                     state_d = RESP;
                    else if (!req_store)             state_d = LOAD;
                    else if (req_funct3 == 3'b011)   state_d = WRITE;
                    else                             state_d = RMW_RD;
                end
            end
            LOAD:    state_d = RESP;
            RMW_RD:  state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: datapath registers are reset too, because mem_addr, mem_wdata and resp_rdata must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q <= '0;
            addr_q   <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        merge_q  <= req_wdata;
                        rdata_q  <= '0;
                        err_q    <= req_bad;
                    end
                end
                LOAD:    rdata_q <= load_ext;
                RMW_RD:  merge_q <= merged;
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_read   = (state_q == LOAD) || (state_q == RMW_RD);
    assign mem_write  = (state_q == WRITE);
    assign mem_addr   = {addr_q[XLEN-1:3], 3'b000};
    assign mem_wdata  = merge_q;

endmodule
